seq_shifter: RTL and testbench

//   Multi-cycle sequential shifter. It performs one single-bit shift or rotate step per clock,

---
 rtl/seq_shifter.sv | 115 +++++++++++
 tb/tb_seq_shifter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle sequential shifter for the npc datapath.
// Each clock applies one single-bit shift or rotate step. The step repeats
// shamt times between a valid/ready request port and a valid/ready response port.
// It is a low-area alternative to the combinational barrel shifter.
module seq_shifter #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  // Operation encodings. Codes 101..111 all mean PASS.
  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [2:0]         op_q;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   step_val;

  // One single-bit step of the selected operation, applied to the result register.
  function automatic logic [WIDTH-1:0] step(input logic [2:0] op, input logic [WIDTH-1:0] r);
    logic [WIDTH-1:0] res;
    case (op)
      OP_SLL:  res = {r[WIDTH-2:0], 1'b0};
      OP_SRL:  res = {1'b0, r[WIDTH-1:1]};
      OP_SRA:  res = {r[WIDTH-1], r[WIDTH-1:1]};
      OP_ROR:  res = {r[0], r[WIDTH-1:1]};
      OP_ROL:  res = {r[WIDTH-2:0], r[WIDTH-1]};
      default: res = r;  // PASS: steps are still counted
    endcase
    return res;
  endfunction

  // Next value of the result register while shifting.
  always_comb begin
    step_val = step(op_q, out_data);
  end

  // Control FSM and datapath. The handshake flags are registers kept in step with state.
  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // see the same pre-edge values, which avoids races between always blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_SLL;
      cnt       <= '0;
      out_data  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            out_data <= in_data;
            op_q     <= in_op;
            cnt      <= in_shamt;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (in_shamt == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          out_data <= step_val;
          cnt      <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // Result is held until the consumer takes it.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed self-checking bench for seq_shifter.
// Inputs change on the falling edge. Outputs are sampled on the falling edge,
// except during the asynchronous reset check.
module tb_seq_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_shamt;
  logic [2:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int checks = 0;
  int errors = 0;

  seq_shifter #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for the result.
  // Checks the latency in edges after accept, busy, the result value and the return to idle.
  task automatic run(input string tag, input logic [2:0] op, input logic [7:0] d,
                     input logic [2:0] sh, input logic [7:0] exp);
    int n;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = op;
    in_data   = d;
    in_shamt  = sh;
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
    n = 0;
    while (!out_valid && n < 20) begin
      chk({tag, "_busy"}, busy, 1);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, n, sh);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_busy_done"}, busy, 1);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_idle"}, in_ready, 1);
    chk({tag, "_valid_low"}, out_valid, 0);
  endtask

  initial begin
    int last;
    int n_acc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_shamt  = 3'd0;
    in_op     = 3'b000;
    out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // 1: SLL
    run("sll3", 3'b000, 8'h96, 3'd3, 8'hB0);
    // 2: SRL / SRA, including the full-width arithmetic shift
    run("srl2", 3'b001, 8'h96, 3'd2, 8'h25);
    run("sra2", 3'b010, 8'h96, 3'd2, 8'hE5);
    run("sra7", 3'b010, 8'h80, 3'd7, 8'hFF);
    // 3: rotates and the round trip
    run("ror3", 3'b011, 8'h96, 3'd3, 8'hD2);
    run("rol3", 3'b100, 8'hD2, 3'd3, 8'h96);
    run("rol1", 3'b100, 8'h81, 3'd1, 8'h03);

    // 4: shamt=0, then back-pressure with ignored request pulses
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 3'b000;
    in_data   = 8'h5A;
    in_shamt  = 3'd0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("sh0_valid", out_valid, 1);
    chk("sh0_data", out_data, 8'h5A);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 8'hC3;
      in_shamt = 3'd1;
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, 8'h5A);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("hold_release_valid", out_valid, 0);
    chk("hold_release_ready", in_ready, 1);
    chk("idle_keeps_data", out_data, 8'h5A);

    // 5: asynchronous reset in the middle of a transaction
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 3'b001;
    in_data  = 8'hFF;
    in_shamt = 3'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", out_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    run("post_rst_sll1", 3'b000, 8'h01, 3'd1, 8'h02);

    // 6: in_valid held high gives back-to-back transactions every shamt+2 cycles
    in_valid = 1'b1;
    in_op    = 3'b000;
    in_data  = 8'h01;
    in_shamt = 3'd2;
    last  = 0;
    n_acc = 0;
    for (int c = 0; c < 13; c++) begin
      if (in_ready) begin
        if (n_acc > 0) chk("accept_gap", c - last, 4);
        last = c;
        n_acc++;
      end
      if (out_valid) chk("stream_data", out_data, 8'h04);
      if (c == 12) in_valid = 1'b0;
      @(negedge clk);
    end
    chk("accept_count", n_acc, 4);

    // Unassigned op code behaves as PASS but still takes shamt steps
    run("pass4", 3'b110, 8'h3C, 3'd4, 8'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
